// File: rtl/dbf_chan_gather_if.sv
// Serial sample input and gathered-frame output bundle for dbf_chan_gather.
// The master side feeds samples; the slave side is the gather block.
interface dbf_chan_gather_if #(
  parameter int unsigned N_CH = 24,
  parameter int unsigned DW   = 32
);
  logic [DW-1:0]      s_data;
  logic               s_valid;
  logic               s_first;
  logic [N_CH*DW-1:0] data_out;
  logic               out_valid;
  logic               sync_err;
  logic [15:0]        frame_cnt;
  logic               busy;

  modport slave (
    input  s_data, s_valid, s_first,
    output data_out, out_valid, sync_err, frame_cnt, busy
  );

  modport master (
    output s_data, s_valid, s_first,
    input  data_out, out_valid, sync_err, frame_cnt, busy
  );
endinterface

// File: rtl/dbf_chan_gather.sv
// Gathers N_CH serial channel samples into one parallel frame for the beamforming summer.
// Flags framing errors and stalled frames, and counts completed frames.
module dbf_chan_gather #(
  parameter int unsigned N_CH    = 24,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  dbf_chan_gather_if.slave  bus
);

  localparam int unsigned IW      = $clog2(N_CH);
  localparam int unsigned TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next, wr_idx;
  logic [TW-1:0] timer, timer_next;
  logic          wr_en, done, err_next;

  // The last channel goes straight from s_data into data_out, so only N_CH-1 slots are stored.
  logic [DW-1:0] col_buf [N_CH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    timer_next = timer;
    wr_en      = 1'b0;
    done       = 1'b0;
    err_next   = 1'b0;
    wr_idx     = bus.s_first ? '0 : idx;
    case (state)
      IDLE: begin
        if (bus.s_valid) begin
          if (bus.s_first) begin
            wr_en      = 1'b1;
            idx_next   = IW'(1);
            timer_next = '0;
            state_next = COLLECT;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.s_valid) begin
          timer_next = '0;
          if (bus.s_first) begin
            // Restart: the partial frame is dropped and this sample becomes channel 0.
            err_next = 1'b1;
            wr_en    = 1'b1;
            idx_next = IW'(1);
          end else if (idx == IW'(N_CH - 1)) begin
            done       = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            wr_en    = 1'b1;
            idx_next = idx + IW'(1);
          end
        end else if ((TIMEOUT != 0) && (timer == TW'(TO_LAST))) begin
          err_next   = 1'b1;
          idx_next   = '0;
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Collection buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH) - 1; i++) col_buf[i] <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.sync_err  <= 1'b0;
      bus.frame_cnt <= '0;
      bus.busy      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_CH) - 1; i++) begin
        if (wr_en && (wr_idx == IW'(i))) col_buf[i] <= bus.s_data;
      end
      bus.out_valid <= done;
      bus.sync_err  <= err_next;
      bus.busy      <= (state_next == COLLECT);
      if (done) begin
        for (int i = 0; i < int'(N_CH) - 1; i++) bus.data_out[i*DW +: DW] <= col_buf[i];
        bus.data_out[(N_CH-1)*DW +: DW] <= bus.s_data;
        bus.frame_cnt <= bus.frame_cnt + 16'(1);
      end
    end
  end

endmodule

// File: tb/tb_dbf_chan_gather.sv
// Self-checking bench for dbf_chan_gather: directed framing scenarios plus random traffic
// compared every cycle against a queue-based frame model.
module tb_dbf_chan_gather;
  localparam int unsigned N_CH    = 24;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned W       = N_CH * DW;

  logic clk = 1'b0;
  logic rst;

  dbf_chan_gather_if #(.N_CH(N_CH), .DW(DW)) bus ();

  dbf_chan_gather #(.N_CH(N_CH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_ov   = 0;
  int n_err  = 0;

  // Reference model: samples of the frame in progress, plus expected outputs.
  logic [DW-1:0] mq[$];
  int            gap;
  logic [W-1:0]  exp_dout;
  logic [15:0]   exp_cnt;
  logic          exp_ov, exp_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    gap      = 0;
    exp_dout = '0;
    exp_cnt  = '0;
    exp_ov   = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic [DW-1:0] d);
    exp_ov  = 1'b0;
    exp_err = 1'b0;
    if (v) begin
      gap = 0;
      if (f) begin
        if (mq.size() != 0) exp_err = 1'b1;
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        mq.push_back(d);
        if (mq.size() == N_CH) begin
          for (int i = 0; i < int'(N_CH); i++) exp_dout[i*DW +: DW] = mq[i];
          exp_cnt = exp_cnt + 16'(1);
          exp_ov  = 1'b1;
          mq.delete();
        end
      end
    end else if (mq.size() != 0) begin
      gap++;
      if (TIMEOUT != 0 && gap == int'(TIMEOUT)) begin
        exp_err = 1'b1;
        mq.delete();
        gap = 0;
      end
    end
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, "_ov"},   W'(bus.out_valid), W'(exp_ov));
    chk({pfx, "_err"},  W'(bus.sync_err),  W'(exp_err));
    chk({pfx, "_busy"}, W'(bus.busy),      W'(mq.size() != 0));
    chk({pfx, "_cnt"},  W'(bus.frame_cnt), W'(exp_cnt));
    chk({pfx, "_dout"}, bus.data_out,      exp_dout);
  endtask

  task automatic step(input logic v, input logic f, input logic [DW-1:0] d);
    bus.s_valid = v;
    bus.s_first = f;
    bus.s_data  = d;
    @(posedge clk);
    model_step(v, f, d);
    #1;
    compare_all("cyc");
    if (bus.out_valid) n_ov++;
    if (bus.sync_err)  n_err++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_data  = '0;
    rst = 1'b1;
    #2;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("rst_rel");
    n_ov  = 0;
    n_err = 0;
  endtask

  logic [W-1:0] frame_a, frame_b;
  logic [DW-1:0] lane;

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_data  = '0;
    model_reset();
    for (int i = 0; i < int'(N_CH); i++) begin
      frame_a[i*DW +: DW] = DW'(i + 1);
      frame_b[i*DW +: DW] = 32'h8000_000F;
    end

    // One clean frame with lane i = i+1.
    do_reset();
    for (int i = 0; i < int'(N_CH); i++) step(1'b1, i == 0, DW'(i + 1));
    chk("s1_ov_now", W'(bus.out_valid), W'(1));
    chk("s1_frame", bus.data_out, frame_a);
    chk("s1_cnt", W'(bus.frame_cnt), W'(1));
    step(1'b0, 1'b0, '0);
    chk("s1_ov_once", W'(n_ov), W'(1));
    chk("s1_no_err", W'(n_err), W'(0));

    // Back-to-back frames A then B; A holds until B completes.
    do_reset();
    for (int i = 0; i < int'(N_CH); i++) step(1'b1, i == 0, DW'(i + 1));
    for (int i = 0; i < int'(N_CH); i++) begin
      step(1'b1, i == 0, 32'h8000_000F);
      if (i == 12) chk("s2_hold_a", bus.data_out, frame_a);
    end
    chk("s2_frame_b", bus.data_out, frame_b);
    chk("s2_ov2", W'(n_ov), W'(2));
    chk("s2_cnt", W'(bus.frame_cnt), W'(2));

    // Restart after 10 samples.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, DW'($urandom));
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("s3_ov_early", W'(n_ov), W'(0));
    for (int i = 1; i < int'(N_CH); i++) step(1'b1, 1'b0, DW'(i));
    lane = bus.data_out[DW-1:0];
    chk("s3_lane0", W'(lane), W'(32'hDEAD_BEEF));
    chk("s3_err1", W'(n_err), W'(1));
    chk("s3_ov1", W'(n_ov), W'(1));
    chk("s3_cnt", W'(bus.frame_cnt), W'(1));

    // Stray samples in IDLE.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b0, 1'b0, '0);
    chk("s4_err3", W'(n_err), W'(3));
    chk("s4_busy", W'(bus.busy), W'(0));
    chk("s4_cnt", W'(bus.frame_cnt), W'(0));

    // Gap of TIMEOUT-1 survives.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, DW'(i + 1));
    idle(int'(TIMEOUT) - 1);
    for (int i = 5; i < int'(N_CH); i++) step(1'b1, 1'b0, DW'(i + 1));
    chk("s5a_frame", bus.data_out, frame_a);
    chk("s5a_ov", W'(n_ov), W'(1));
    chk("s5a_err", W'(n_err), W'(0));

    // Gap of TIMEOUT times out.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, DW'(i + 1));
    idle(int'(TIMEOUT) - 1);
    chk("s5b_busy_pre", W'(bus.busy), W'(1));
    idle(1);
    chk("s5b_err_now", W'(bus.sync_err), W'(1));
    chk("s5b_busy", W'(bus.busy), W'(0));
    idle(2);
    chk("s5b_err1", W'(n_err), W'(1));
    chk("s5b_ov0", W'(n_ov), W'(0));

    // Reset in the middle of a frame, then a full frame.
    do_reset();
    for (int i = 0; i < int'(N_CH); i++) step(1'b1, i == 0, DW'($urandom));
    for (int i = 0; i < 12; i++) step(1'b1, i == 0, DW'($urandom));
    do_reset();
    chk("s6_busy0", W'(bus.busy), W'(0));
    chk("s6_dout0", bus.data_out, W'(0));
    for (int i = 0; i < int'(N_CH); i++) step(1'b1, i == 0, DW'(i + 1));
    chk("s6_frame", bus.data_out, frame_a);
    chk("s6_cnt", W'(bus.frame_cnt), W'(1));

    // Random traffic with occasional restarts, stray samples and long gaps.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle(int'($urandom_range(TIMEOUT - 4, TIMEOUT + 4)));
      end else begin
        logic v, f;
        v = ($urandom_range(0, 99) < 80);
        f = v && ((mq.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0));
        step(v, f, DW'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
